// File: rtl/inst_pipe_regs.sv
// inst_pipe_regs: instruction/PC pipeline register chain for the 5-stage core.
// Holds the fetch PC and the R, X, M, W and END instruction latches. Bubbles
// are inserted behind a held stage, and wrong-path R/X contents are squashed
// when X resolves a taken branch/jump (flush = redirect & en_x).
//
// Ports:
//   clk, rst_n          core clock, synchronous active-low reset
//   en_f..en_w          per-stage enables from the pipeline controller
//   redirect            taken branch/jump resolved in X
//   redirect_pc         redirect target
//   imem_data           instruction at imem_addr (asynchronous read)
//   imem_addr           fetch PC (the PC register itself)
//   inst_r..inst_end    stage instruction words decoded by the controller
//   pc_r, pc_x          PC+1 of the instructions in R and X
//   stall_cnt,flush_cnt saturating event counters, present only when
//                       PIPE_PERF_CNT_EN is defined
module inst_pipe_regs #(
  parameter logic [15:0] BUBBLE_INST = 16'hFFFF,
  parameter logic [15:0] RESET_PC    = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_f,
  input  logic        en_r,
  input  logic        en_x,
  input  logic        en_m,
  input  logic        en_w,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic [15:0] imem_data,
  output logic [15:0] imem_addr,
  output logic [15:0] inst_r,
  output logic [15:0] inst_x,
  output logic [15:0] inst_m,
  output logic [15:0] inst_w,
  output logic [15:0] inst_end,
`ifdef PIPE_PERF_CNT_EN
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
`endif
  output logic [15:0] pc_r,
  output logic [15:0] pc_x
);

  localparam int unsigned XLEN = 16;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_inc;
  logic            flush;

  // A redirect only counts once X actually advances; a held branch re-asserts.
  assign flush     = redirect & en_x;
  assign pc_inc    = pc + XLEN'(1);
  assign imem_addr = pc;

  // Fetch PC
  always_ff @(posedge clk) begin
    if (!rst_n)      pc <= RESET_PC;
    else if (flush)  pc <= redirect_pc;
    else if (en_f)   pc <= pc_inc;
  end

  // R stage: pc_r is left untouched on flush since the slot becomes a bubble
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inst_r <= BUBBLE_INST;
      pc_r   <= '0;
    end else if (flush) begin
      inst_r <= BUBBLE_INST;
    end else if (en_r) begin
      if (en_f) begin
        inst_r <= imem_data;
        pc_r   <= pc_inc;
      end else begin
        inst_r <= BUBBLE_INST;
      end
    end
  end

  // X stage: en_x with en_r low is the load-use bubble
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inst_x <= BUBBLE_INST;
      pc_x   <= '0;
    end else if (flush) begin
      inst_x <= BUBBLE_INST;
    end else if (en_x) begin
      if (en_r) begin
        inst_x <= inst_r;
        pc_x   <= pc_r;
      end else begin
        inst_x <= BUBBLE_INST;
      end
    end
  end

  // M and W stages; the branch in X still moves to M on its own flush
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inst_m <= BUBBLE_INST;
      inst_w <= BUBBLE_INST;
    end else begin
      if (en_m) inst_m <= en_x ? inst_x : BUBBLE_INST;
      if (en_w) inst_w <= en_m ? inst_m : BUBBLE_INST;
    end
  end

  // END stage is reloaded every cycle for late forwarding
  always_ff @(posedge clk) begin
    if (!rst_n) inst_end <= BUBBLE_INST;
    else        inst_end <= en_w ? inst_w : BUBBLE_INST;
  end

`ifdef PIPE_PERF_CNT_EN
  // Saturating stall/flush event counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!en_f && (stall_cnt != '1)) stall_cnt <= stall_cnt + XLEN'(1);
      if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + XLEN'(1);
    end
  end
`endif

endmodule

// File: tb/tb_inst_pipe_regs.sv
module tb_inst_pipe_regs;

  localparam logic [15:0] BUB  = 16'hFFFF;
  localparam logic [15:0] RPC  = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n, en_f, en_r, en_x, en_m, en_w, redirect;
  logic [15:0] redirect_pc, imem_data, imem_addr;
  logic [15:0] inst_r, inst_x, inst_m, inst_w, inst_end, pc_r, pc_x;
`ifdef PIPE_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif
  logic        use_fixed;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: program counter, stage contents R,X,M,W,END and PC tags
  logic [15:0] m_pc;
  logic [15:0] m_inst [5];
  logic [15:0] m_pcr, m_pcx;
  int          m_stall, m_flush;

  always #5 clk = ~clk;

  // Memory image: address n holds 16'hA000+n
  assign imem_data = use_fixed ? 16'h1234 : 16'hA000 + imem_addr;

  inst_pipe_regs #(.BUBBLE_INST(BUB), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .en_f(en_f), .en_r(en_r), .en_x(en_x),
    .en_m(en_m), .en_w(en_w), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_data(imem_data), .imem_addr(imem_addr), .inst_r(inst_r),
    .inst_x(inst_x), .inst_m(inst_m), .inst_w(inst_w), .inst_end(inst_end),
`ifdef PIPE_PERF_CNT_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .pc_r(pc_r), .pc_x(pc_x)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of the behavioural pipeline: a slot advances when it and its
  // upstream are enabled, gets a bubble when only it is enabled, else holds.
  task automatic model_clk();
    logic [15:0] nxt [5];
    logic        en_s [5];
    logic        up_en, fl;
    logic [15:0] up_val, data;
    if (!rst_n) begin
      m_pc = RPC;
      for (int i = 0; i < 5; i++) m_inst[i] = BUB;
      m_pcr = 16'h0; m_pcx = 16'h0;
      m_stall = 0; m_flush = 0;
      return;
    end
    fl   = redirect & en_x;
    data = use_fixed ? 16'h1234 : 16'hA000 + m_pc;
    en_s[0] = en_r; en_s[1] = en_x; en_s[2] = en_m; en_s[3] = en_w; en_s[4] = 1'b1;
    for (int s = 0; s < 5; s++) begin
      up_en  = (s == 0) ? en_f : en_s[s-1];
      up_val = (s == 0) ? data : m_inst[s-1];
      nxt[s] = en_s[s] ? (up_en ? up_val : BUB) : m_inst[s];
    end
    if (fl) begin
      nxt[0] = BUB;
      nxt[1] = BUB;
    end else begin
      if (en_x && en_r) m_pcx = m_pcr;
      if (en_r && en_f) m_pcr = m_pc + 16'd1;
    end
    for (int s = 0; s < 5; s++) m_inst[s] = nxt[s];
    if (!en_f && m_stall < 65535) m_stall++;
    if (fl && m_flush < 65535) m_flush++;
    m_pc = fl ? redirect_pc : (en_f ? m_pc + 16'd1 : m_pc);
  endtask

  task automatic check_all();
    chk("imem_addr", imem_addr, m_pc);
    chk("inst_r", inst_r, m_inst[0]);
    chk("inst_x", inst_x, m_inst[1]);
    chk("inst_m", inst_m, m_inst[2]);
    chk("inst_w", inst_w, m_inst[3]);
    chk("inst_end", inst_end, m_inst[4]);
    chk("pc_r", pc_r, m_pcr);
    chk("pc_x", pc_x, m_pcx);
`ifdef PIPE_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, 16'(m_stall));
    chk("flush_cnt", flush_cnt, 16'(m_flush));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_clk();
    #1;
    check_all();
  endtask

  task automatic set_en(input logic f, r, x, m, w);
    en_f = f; en_r = r; en_x = x; en_m = m; en_w = w;
  endtask

  initial begin
    rst_n = 1'b0; use_fixed = 1'b1; redirect = 1'b0; redirect_pc = 16'h0;
    set_en(1, 1, 1, 1, 1);
    for (int i = 0; i < 5; i++) m_inst[i] = 16'hxxxx;

    // Reset with a live-looking imem word
    step(); step();
    chk("rst_addr", imem_addr, RPC);
    chk("rst_inst_r", inst_r, 16'hFFFF);
    chk("rst_inst_end", inst_end, 16'hFFFF);
    chk("rst_pc_x", pc_x, 16'h0000);

    // Straight-line flow
    rst_n = 1'b1; use_fixed = 1'b0;
    step();
    chk("sl_inst_r", inst_r, 16'hA000);
    chk("sl_pc_r", pc_r, 16'h0001);
    step(); step(); step();
    chk("sl_inst_x", inst_x, 16'hA002);
    chk("sl_addr", imem_addr, 16'h0004);

    // Load-use stall with A002 in X
    set_en(0, 0, 1, 1, 1);
    step();
    chk("lu_inst_r_hold", inst_r, 16'hA003);
    chk("lu_addr_hold", imem_addr, 16'h0004);
    chk("lu_inst_x_bub", inst_x, 16'hFFFF);
    chk("lu_inst_m", inst_m, 16'hA002);
    chk("sl_inst_end", inst_end, 16'hA000);
    set_en(1, 1, 1, 1, 1);
    step();
    chk("lu_no_dup_x", inst_x, 16'hA003);
    chk("lu_no_dup_m", inst_m, 16'hFFFF);

    // Flush with A003 in X
    redirect = 1'b1; redirect_pc = 16'h0040;
    step();
    chk("fl_addr", imem_addr, 16'h0040);
    chk("fl_inst_r", inst_r, 16'hFFFF);
    chk("fl_inst_x", inst_x, 16'hFFFF);
    chk("fl_inst_m", inst_m, 16'hA003);
    redirect = 1'b0;
    step();
    chk("fl_target", inst_r, 16'hA040);

    // Redirect held in X is ignored
    redirect = 1'b1; redirect_pc = 16'h0123;
    set_en(0, 0, 0, 1, 1);
    step();
    chk("rdx0_addr", imem_addr, 16'h0041);
    chk("rdx0_inst_r", inst_r, 16'hA040);
    chk("rdx0_inst_x", inst_x, 16'hFFFF);

    // PC wrap at 16'hFFFF
    set_en(1, 1, 1, 1, 1); redirect_pc = 16'hFFFF;
    step();
    chk("wrap_pre", imem_addr, 16'hFFFF);
    redirect = 1'b0;
    step();
    chk("wrap_post", imem_addr, 16'h0000);

    // Flush together with en_r=0
    step(); step();
    redirect = 1'b1; redirect_pc = 16'h0200;
    set_en(1, 0, 1, 1, 1);
    step();
    chk("flr0_inst_r", inst_r, 16'hFFFF);
    chk("flr0_inst_x", inst_x, 16'hFFFF);
    redirect = 1'b0; set_en(1, 1, 1, 1, 1);

`ifdef PIPE_PERF_CNT_EN
    rst_n = 1'b0; step(); rst_n = 1'b1;
    set_en(0, 1, 1, 1, 1);
    step(); step(); step();
    set_en(1, 1, 1, 1, 1); redirect = 1'b1; redirect_pc = 16'h0010;
    step(); step();
    redirect = 1'b0;
    chk("cnt_stall3", stall_cnt, 16'd3);
    chk("cnt_flush2", flush_cnt, 16'd2);
    set_en(0, 0, 0, 0, 0);
    for (int i = 0; i < 70000; i++) begin
      @(posedge clk);
      model_clk();
    end
    #1;
    chk("cnt_sat", stall_cnt, 16'hFFFF);
    check_all();
    set_en(1, 1, 1, 1, 1);
`endif

    // Randomized enables, redirects and occasional resets
    for (int i = 0; i < 3000; i++) begin
      rst_n       = ($urandom_range(99) != 0);
      en_f        = ($urandom_range(3) != 0);
      en_r        = ($urandom_range(3) != 0);
      en_x        = ($urandom_range(3) != 0);
      en_m        = ($urandom_range(4) != 0);
      en_w        = ($urandom_range(4) != 0);
      redirect    = ($urandom_range(5) == 0);
      redirect_pc = 16'($urandom_range(16'h0FFF));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_pipe_regs.md
Name: inst_pipe_regs

Overview:
- Instruction/PC pipeline register chain for the 5-stage core: fetch PC, then R, X, M, W and END instruction latches.
- Consumes the per-stage enables from the pipeline controller and drives back the inst_r/inst_x/inst_m/inst_w/inst_end words that the controller decodes for stalls and forwarding.
- Inserts bubbles on stalls, flushes wrong-path instructions on a taken branch/jump redirect from X, and generates the instruction-memory address.

Parameters:
- BUBBLE_INST, 16'hFFFF, encoding injected as a bubble. Must decode in the controller as no register read and no register write.
- RESET_PC, 16'h0000, PC value after reset.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  synchronous reset, active-low
- en_f  in  1  fetch stage enable
- en_r  in  1  R stage enable
- en_x  in  1  X stage enable
- en_m  in  1  M stage enable
- en_w  in  1  W stage enable
- redirect  in  1  taken branch/jump resolved in X
- redirect_pc  in  16  target PC for redirect
- imem_data  in  16  instruction word at imem_addr, asynchronous read, same cycle
- imem_addr  out  16  current fetch PC, combinational from PC register
- inst_r  out  16  instruction in R
- inst_x  out  16  instruction in X
- inst_m  out  16  instruction in M
- inst_w  out  16  instruction in W
- inst_end  out  16  instruction retired last cycle; used for late forwarding
- pc_r  out  16  PC+1 of the instruction in R
- pc_x  out  16  PC+1 of the instruction in X

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - pc <= RESET_PC.
  - All inst_* <= BUBBLE_INST.
  - pc_r, pc_x <= 0.
  - Reset has priority over every other input, including a reset that lands mid-stall or mid-flush.
- flush = redirect & en_x. A redirect while en_x=0 is ignored: the branch is still held in X and re-asserts redirect later.
- PC register:
  - If flush: pc <= redirect_pc.
  - Else if en_f: pc <= pc+1, modulo 2^16, so 16'hFFFF wraps to 0.
  - Otherwise pc holds.
- imem_addr = pc.
- R stage:
  - If flush: inst_r <= BUBBLE_INST. pc_r holds.
  - Else if en_r and en_f: inst_r <= imem_data; pc_r <= pc+1.
  - Else if en_r and not en_f: inst_r <= BUBBLE_INST.
  - Else: hold.
- X stage:
  - If flush: inst_x <= BUBBLE_INST.
  - Else if en_x and en_r: inst_x <= inst_r; pc_x <= pc_r.
  - Else if en_x and not en_r: inst_x <= BUBBLE_INST. This is the load-use stall bubble.
  - Else: hold.
- M stage: if en_m, inst_m <= (en_x ? inst_x : BUBBLE_INST); else hold. The branch itself advances normally on a flush.
- W stage: if en_w, inst_w <= (en_m ? inst_m : BUBBLE_INST); else hold.
- END stage: loaded every cycle, inst_end <= (en_w ? inst_w : BUBBLE_INST).
- Latency: an instruction fetched at cycle t appears on inst_r at t+1, inst_x t+2, inst_m t+3, inst_w t+4, inst_end t+5, assuming no stall.
- A stalled instruction is never duplicated. Only a bubble fills the slot downstream of a held stage.
- Simultaneous stall and flush: flush dominates R and X. Stages M, W and END still obey their own enables.
- Any enable may fall in any cycle.
- No combinational path exists from the en_* inputs to any inst_* output.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- When defined, two extra outputs are added:
  - stall_cnt [15:0]: increments in each cycle with rst_n=1 and en_f=0.
  - flush_cnt [15:0]: increments in each cycle with flush=1.
  - Both reset to 0, saturate at 16'hFFFF, and do not wrap.
- When undefined, neither port nor any counter logic exists. All other behaviour is identical.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with imem_data=16'h1234 -> imem_addr=RESET_PC; all inst_*=16'hFFFF; pc_r=pc_x=0.
- Straight line: all en=1; imem_data = instruction at addr n is 16'hA000+n -> inst_r=16'hA000 one cycle after reset release, inst_end=16'hA000 five cycles after; imem_addr increments by 1 each cycle.
- Load-use stall: en_f=en_r=0 for 1 cycle while inst_x=16'hA002 -> inst_r holds; pc holds; next inst_x=16'hFFFF; inst_m=16'hA002; no instruction is duplicated downstream.
- Flush: redirect=1 and redirect_pc=16'h0040 while inst_x=16'hA003 -> next cycle imem_addr=16'h0040; inst_r=inst_x=16'hFFFF; inst_m=16'hA003; then inst_r=16'hA040.
- Corner cases:
  - redirect=1 with en_x=0 -> no state change in pc, R or X.
  - pc=16'hFFFF with en_f=1 -> next pc=16'h0000.
  - Flush together with en_r=0 -> R and X become bubbles.
- With PIPE_PERF_CNT_EN:
  - 3 stall cycles and 2 flushes -> stall_cnt=3, flush_cnt=2.
  - Force 70000 stall cycles -> stall_cnt stays at 16'hFFFF.
